instr_fetch_decode: RTL and testbench
=====================================

# instr_fetch_decode

Fetch/decode stage of the multicycle ARM32 core, directly upstream of `controller`. It owns the program counter and instruction register, and runs a short state machine that reads one instruction word from the synchronous instruction RAM. It decodes the latched word into the fields `controller` and the datapath consume: opcode, cond, rn, rd, rm, rs, shift_op, shift_imme, imme_data and en_status.

## Interface
- `ADDR_W`, default 9: word-address width of the instruction RAM.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `fetch_req`  in  1: start a fetch at the current pc. Driven by the controller `load_ir`.
- `load_pc`  in  1: load `pc_in` into pc.
- `clear_pc`  in  1: force pc to 0.
- `pc_in`  in  32: branch target from the datapath.
- `ram_rdata`  in  32: RAM read data, valid one cycle after the address.
- `ram_addr`  out  ADDR_W: equals pc[ADDR_W+1:2].
- `pc`  out  32: current program counter.
- `busy`  out  1: high in READ and CAPTURE.
- `ir_valid`  out  1: high in VALID.
- `opcode`  out  7: {class[2:0], alu[3:0]}.
- `cond`  out  4: condition field.
- `rn`, `rd`, `rm`, `rs`  out  4 each: register fields.
- `shift_op`  out  2: shift type.
- `shift_imme`  out  5: immediate shift amount.
- `imme_data`  out  32: expanded immediate.
- `en_status`  out  1: S bit.

## Operation
- **States:** IDLE, READ, CAPTURE, VALID.
- **Fetch sequence:**
  - IDLE or VALID with `fetch_req` → READ.
  - READ → CAPTURE unconditionally.
  - CAPTURE: ir <= `ram_rdata`, pc <= pc+4, then → VALID.
  - VALID holds until the next `fetch_req`.
- **Busy handling:** `fetch_req` is ignored while busy.
- **PC priority:** `clear_pc` > `load_pc` > CAPTURE increment.
  - `clear_pc` or `load_pc` in READ or CAPTURE aborts the fetch: → IDLE, ir is not updated, no increment.
  - In IDLE or VALID they update pc only; state is unchanged. In VALID, ir_valid stays high.
- **PC width:** pc wraps modulo 2^32. `ram_addr` ignores pc[1:0] and pc[31:ADDR_W+2].
- **Field decode:** combinational from ir, always driven, including when not valid.
  - cond=ir[31:28], en_status=ir[20], rn=ir[19:16], rd=ir[15:12], rs=ir[11:8], shift_imme=ir[11:7], shift_op=ir[6:5], rm=ir[3:0].
- **Class:**
  - ir[27:26]≠00 → opcode 7'h7F (undefined).
  - Otherwise ir[25]=1 → 001 (immediate); ir[4]=0 → 000 (register, immediate shift); ir[7]=0 → 010 (register shifted by register); else 7'h7F.
- **ALU nibble** from ir[24:21]: AND→0010, EOR→0100, SUB→0001, ADD→0000, TST→0110, CMP→0101, ORR→0011, MOV→1000, MVN→1001. Any other value → 7'h7F.
- **imme_data:** zero-extended ir[7:0] rotated right by 2·ir[11:8]. Driven for every class.

## Timing
- **Reset values:** state IDLE, pc=0, ir=0, busy=0, ir_valid=0, `ram_addr`=0. Decoded outputs follow ir=0: opcode 0000010, all register fields 0, imme_data 0.
- **Latency:** `fetch_req` sampled at edge n → READ after n; ir loaded at edge n+2. `ir_valid` and the decoded fields are valid after n+2.
- **Back-to-back fetches:** `fetch_req` held in VALID starts the next fetch immediately. Throughput is one instruction per 3 cycles.
- **Reset mid-fetch:** asynchronous return to the reset values. No partial ir update.
- **RAM contract:** `ram_addr` is stable for the whole of READ. `ram_rdata` is sampled only in CAPTURE.

## Structure
- Shared package `arm_pkg` holds:
  - the state enum;
  - the class and ALU-code constants;
  - OPC_UNDEF = 7'h7F.
- One sub-module, `imm_expand`: combinational rotate of imm8 by rot4. Also reusable by the datapath.
- FSM, pc and ir registers, and the field/opcode decode live in `instr_fetch_decode`.

## Test plan
- Reset, then RAM[0]=E3A00008 with `fetch_req` pulsed → ir_valid after 2 cycles; opcode 0011000, rd 0, imme_data 8, pc 4.
- RAM[1]=E1A010A0 → opcode 0001000, rd 1, rm 0, shift_op 01, shift_imme 1.
  - RAM[2]=E0411010 → opcode 0100001, rn 1, rd 1, rs 0.
- RAM word E3A004FF → imme_data FF000000.
  - A word with ir[27:26]=01 → opcode 7F.
- `load_pc` with pc_in=0x40 asserted in READ → state IDLE, ir unchanged, pc 0x40. The next fetch reads `ram_addr` 0x10.
- `clear_pc` and `load_pc` asserted together → pc 0.
  - `fetch_req` in CAPTURE is ignored.
  - `rst_n` low in READ → pc 0, ir_valid 0 immediately.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared types and constants for the ARM32 fetch/decode stage.
// State enum, instruction class and ALU codes, ALU nibble mapping.
package arm_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_READ    = 2'd1,
    S_CAPTURE = 2'd2,
    S_VALID   = 2'd3
  } state_t;

  localparam logic [2:0] CLS_REG = 3'b000;
  localparam logic [2:0] CLS_IMM = 3'b001;
  localparam logic [2:0] CLS_RSR = 3'b010;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_ORR = 4'b0011;
  localparam logic [3:0] ALU_EOR = 4'b0100;
  localparam logic [3:0] ALU_CMP = 4'b0101;
  localparam logic [3:0] ALU_TST = 4'b0110;
  localparam logic [3:0] ALU_MOV = 4'b1000;
  localparam logic [3:0] ALU_MVN = 4'b1001;

  localparam logic [6:0] OPC_UNDEF = 7'h7F;

  // Returns {supported, alu_code} for an ARM data-processing nibble.
  function automatic logic [4:0] alu_map(input logic [3:0] dp);
    logic [4:0] r;
    r = 5'b0;
    unique case (dp)
      4'h0:    r = {1'b1, ALU_AND};
      4'h1:    r = {1'b1, ALU_EOR};
      4'h2:    r = {1'b1, ALU_SUB};
      4'h4:    r = {1'b1, ALU_ADD};
      4'h8:    r = {1'b1, ALU_TST};
      4'hA:    r = {1'b1, ALU_CMP};
      4'hC:    r = {1'b1, ALU_ORR};
      4'hD:    r = {1'b1, ALU_MOV};
      4'hF:    r = {1'b1, ALU_MVN};
      default: r = 5'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/instr_fetch_decode_if.sv
// Bundle between fetch/decode, its controller, RAM and datapath.
// master: fetch/decode side; slave: controller/RAM/datapath side.
interface instr_fetch_decode_if #(
  parameter int ADDR_W = 9
);
  logic              fetch_req;
  logic              load_pc;
  logic              clear_pc;
  logic [31:0]       pc_in;
  logic [31:0]       ram_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       pc;
  logic              busy;
  logic              ir_valid;
  logic [6:0]        opcode;
  logic [3:0]        cond;
  logic [3:0]        rn;
  logic [3:0]        rd;
  logic [3:0]        rm;
  logic [3:0]        rs;
  logic [1:0]        shift_op;
  logic [4:0]        shift_imme;
  logic [31:0]       imme_data;
  logic              en_status;

  modport master (
    input  fetch_req, load_pc, clear_pc,
    input  pc_in, ram_rdata,
    output ram_addr, pc, busy, ir_valid,
    output opcode, cond, rn, rd, rm, rs,
    output shift_op, shift_imme,
    output imme_data, en_status
  );

  modport slave (
    output fetch_req, load_pc, clear_pc,
    output pc_in, ram_rdata,
    input  ram_addr, pc, busy, ir_valid,
    input  opcode, cond, rn, rd, rm, rs,
    input  shift_op, shift_imme,
    input  imme_data, en_status
  );
endinterface

// File: rtl/imm_expand.sv
// ARM modified-immediate expansion: imm8 rotated right by 2*rot4.
// Ports: i_imm8, i_rot4 in; o_imm 32-bit out. Pure combinational.
module imm_expand (
  input  logic [7:0]  i_imm8,
  input  logic [3:0]  i_rot4,
  output logic [31:0] o_imm
);
  logic [31:0] w_ext;
  logic [5:0]  w_sh;

  assign w_ext = {24'd0, i_imm8};
  assign w_sh  = {1'b0, i_rot4, 1'b0};

  // A left shift by 32 yields zero, so rot4=0 passes through.
  assign o_imm = (w_ext >> w_sh) | (w_ext << (6'd32 - w_sh));
endmodule

// File: rtl/instr_fetch_decode.sv
// Fetch/decode stage: pc, ir, 4-state fetch FSM, field decode.
// Ports: clk, rst_n (async low), bus (instr_fetch_decode_if.master).
module instr_fetch_decode
  import arm_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  instr_fetch_decode_if.master  bus
);
  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic        r_busy;
  logic        r_ir_valid;

  logic        w_abort;
  logic [2:0]  w_cls;
  logic        w_cls_ok;
  logic [4:0]  w_alu;
  logic [31:0] w_imm;

  assign w_abort = bus.clear_pc | bus.load_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pc       <= '0;
      r_ir       <= '0;
      r_busy     <= 1'b0;
      r_ir_valid <= 1'b0;
    end else begin
      if (bus.clear_pc) begin
        r_pc <= '0;
      end else if (bus.load_pc) begin
        r_pc <= bus.pc_in;
      end
      unique case (r_state)
        S_IDLE, S_VALID: begin
          if (bus.fetch_req) begin
            r_state    <= S_READ;
            r_busy     <= 1'b1;
            r_ir_valid <= 1'b0;
          end
        end
        S_READ: begin
          if (w_abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (w_abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_ir       <= bus.ram_rdata;
            r_pc       <= r_pc + 32'd4;
            r_state    <= S_VALID;
            r_busy     <= 1'b0;
            r_ir_valid <= 1'b1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_busy     <= 1'b0;
          r_ir_valid <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_cls    = CLS_REG;
    w_cls_ok = 1'b0;
    unique case (1'b1)
      (r_ir[27:26] != 2'b00): begin
        w_cls_ok = 1'b0;
      end
      (r_ir[27:25] == 3'b001): begin
        w_cls    = CLS_IMM;
        w_cls_ok = 1'b1;
      end
      (r_ir[27:25] == 3'b000 && !r_ir[4]): begin
        w_cls    = CLS_REG;
        w_cls_ok = 1'b1;
      end
      (r_ir[27:25] == 3'b000 && r_ir[4]
        && !r_ir[7]): begin
        w_cls    = CLS_RSR;
        w_cls_ok = 1'b1;
      end
      default: begin
        w_cls_ok = 1'b0;
      end
    endcase
  end

  assign w_alu = alu_map(r_ir[24:21]);

  imm_expand u_imm (
    .i_imm8 (r_ir[7:0]),
    .i_rot4 (r_ir[11:8]),
    .o_imm  (w_imm)
  );

  assign bus.ram_addr   = r_pc[ADDR_W+1:2];
  assign bus.pc         = r_pc;
  assign bus.busy       = r_busy;
  assign bus.ir_valid   = r_ir_valid;
  assign bus.opcode     = (w_cls_ok && w_alu[4])
                        ? {w_cls, w_alu[3:0]}
                        : OPC_UNDEF;
  assign bus.cond       = r_ir[31:28];
  assign bus.en_status  = r_ir[20];
  assign bus.rn         = r_ir[19:16];
  assign bus.rd         = r_ir[15:12];
  assign bus.rs         = r_ir[11:8];
  assign bus.shift_imme = r_ir[11:7];
  assign bus.shift_op   = r_ir[6:5];
  assign bus.rm         = r_ir[3:0];
  assign bus.imme_data  = w_imm;
endmodule

// File: tb/tb_instr_fetch_decode.sv
// Self-checking bench for instr_fetch_decode.
// Random and directed fetches against a behavioural decode model.
module tb_instr_fetch_decode;
  localparam int AW = 9;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_decode_if #(.ADDR_W(AW)) bus ();

  instr_fetch_decode #(.ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem [0:DEPTH-1];
  always @(posedge clk) bus.ram_rdata <= mem[bus.ram_addr];

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_pc;
  logic [31:0] last_w;

  // Behavioural decode, from the instruction-format rules.
  function automatic logic [6:0] ref_opc(input logic [31:0] w);
    logic [2:0] cls;
    logic [3:0] alu;
    if (w[27:26] != 2'b00) return 7'h7F;
    if (w[25]) cls = 3'b001;
    else if (!w[4]) cls = 3'b000;
    else if (!w[7]) cls = 3'b010;
    else return 7'h7F;
    case (w[24:21])
      4'd0:  alu = 4'b0010;
      4'd1:  alu = 4'b0100;
      4'd2:  alu = 4'b0001;
      4'd4:  alu = 4'b0000;
      4'd8:  alu = 4'b0110;
      4'd10: alu = 4'b0101;
      4'd12: alu = 4'b0011;
      4'd13: alu = 4'b1000;
      4'd15: alu = 4'b1001;
      default: return 7'h7F;
    endcase
    return {cls, alu};
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] w);
    logic [31:0] r;
    r = {24'd0, w[7:0]};
    for (int k = 0; k < 2 * int'(w[11:8]); k++)
      r = {r[0], r[31:1]};
    return r;
  endfunction

  function automatic logic [66:0] ref_f(input logic [31:0] w);
    return {ref_opc(w), w[31:28], w[19:16], w[15:12],
            w[3:0], w[11:8], w[6:5], w[11:7],
            ref_imm(w), w[20]};
  endfunction

  function automatic logic [66:0] act_f();
    return {bus.opcode, bus.cond, bus.rn, bus.rd,
            bus.rm, bus.rs, bus.shift_op, bus.shift_imme,
            bus.imme_data, bus.en_status};
  endfunction

  // Pulse fetch_req one cycle; count negedges until ir_valid.
  task automatic do_fetch(output int cyc);
    @(negedge clk) bus.fetch_req = 1'b1;
    @(negedge clk) bus.fetch_req = 1'b0;
    cyc = 1;
    while (!bus.ir_valid && cyc < 8) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic set_pc(input logic [31:0] v);
    @(negedge clk);
    bus.load_pc = 1'b1;
    bus.pc_in = v;
    @(negedge clk);
    bus.load_pc = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.pc, bus.busy, bus.ir_valid, bus.ram_addr}
        !== {32'd0, 1'b0, 1'b0, 9'd0}) begin
      n_err++;
      $display("FAIL reset_state: got pc=%h b=%b v=%b a=%h",
               bus.pc, bus.busy, bus.ir_valid, bus.ram_addr);
    end
    n_cmp++;
    if (act_f() !== {7'b0000010, 60'd0}) begin
      n_err++;
      $display("FAIL reset_fields: got %h want %h",
               act_f(), {7'b0000010, 60'd0});
    end
    exp_pc = 32'd0;
  endtask

  task automatic test_directed;
    int cyc;
    mem[0] = 32'hE3A00008;
    mem[1] = 32'hE1A010A0;
    mem[2] = 32'hE0411010;
    mem[3] = 32'hE3A004FF;
    mem[4] = 32'h04000000;
    do_fetch(cyc);
    n_cmp++;
    if (cyc !== 3) begin
      n_err++;
      $display("FAIL latency: got %0d want 3", cyc);
    end
    n_cmp++;
    if ({bus.opcode, bus.rd, bus.imme_data, bus.pc}
        !== {7'b0011000, 4'd0, 32'd8, 32'd4}) begin
      n_err++;
      $display("FAIL mov_imm: got opc=%b rd=%h imm=%h pc=%h",
               bus.opcode, bus.rd, bus.imme_data, bus.pc);
    end
    do_fetch(cyc);
    n_cmp++;
    if ({bus.opcode, bus.rd, bus.rm, bus.shift_op,
         bus.shift_imme}
        !== {7'b0001000, 4'd1, 4'd0, 2'b01, 5'd1}) begin
      n_err++;
      $display("FAIL mov_reg: got opc=%b rd=%h rm=%h so=%b si=%h",
               bus.opcode, bus.rd, bus.rm, bus.shift_op,
               bus.shift_imme);
    end
    do_fetch(cyc);
    n_cmp++;
    if ({bus.opcode, bus.rn, bus.rd, bus.rs}
        !== {7'b0100001, 4'd1, 4'd1, 4'd0}) begin
      n_err++;
      $display("FAIL sub_rsr: got opc=%b rn=%h rd=%h rs=%h",
               bus.opcode, bus.rn, bus.rd, bus.rs);
    end
    do_fetch(cyc);
    n_cmp++;
    if (bus.imme_data !== 32'hFF000000) begin
      n_err++;
      $display("FAIL imm_rot: got %h want FF000000",
               bus.imme_data);
    end
    do_fetch(cyc);
    n_cmp++;
    if ({bus.opcode, bus.pc} !== {7'h7F, 32'd20}) begin
      n_err++;
      $display("FAIL undef: got opc=%h pc=%h want 7f/14",
               bus.opcode, bus.pc);
    end
    last_w = mem[4];
    exp_pc = 32'd20;
  endtask

  task automatic test_abort_load;
    logic [31:0] w16;
    w16 = $urandom;
    w16[27:26] = 2'b00;
    mem[16] = w16;
    @(negedge clk) bus.fetch_req = 1'b1;
    @(negedge clk);
    bus.fetch_req = 1'b0;
    bus.load_pc = 1'b1;
    bus.pc_in = 32'h40;
    @(negedge clk);
    bus.load_pc = 1'b0;
    n_cmp++;
    if ({bus.busy, bus.ir_valid, bus.pc, act_f()}
        !== {1'b0, 1'b0, 32'h40, ref_f(last_w)}) begin
      n_err++;
      $display("FAIL abort_read: got b=%b v=%b pc=%h f=%h",
               bus.busy, bus.ir_valid, bus.pc, act_f());
    end
    @(negedge clk) bus.fetch_req = 1'b1;
    @(negedge clk) bus.fetch_req = 1'b0;
    n_cmp++;
    if ({bus.busy, bus.ram_addr} !== {1'b1, 9'h10}) begin
      n_err++;
      $display("FAIL addr_read: got b=%b a=%h want 1/010",
               bus.busy, bus.ram_addr);
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.busy, bus.ram_addr} !== {1'b1, 9'h10}) begin
      n_err++;
      $display("FAIL addr_capt: got b=%b a=%h want 1/010",
               bus.busy, bus.ram_addr);
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.ir_valid, bus.pc, act_f()}
        !== {1'b1, 32'h44, ref_f(w16)}) begin
      n_err++;
      $display("FAIL after_abort: got v=%b pc=%h f=%h want %h",
               bus.ir_valid, bus.pc, act_f(), ref_f(w16));
    end
    last_w = w16;
  endtask

  task automatic test_clear_pc;
    int cyc;
    @(negedge clk) bus.fetch_req = 1'b1;
    @(negedge clk) bus.fetch_req = 1'b0;
    @(negedge clk) bus.clear_pc = 1'b1;
    @(negedge clk) bus.clear_pc = 1'b0;
    n_cmp++;
    if ({bus.busy, bus.ir_valid, bus.pc, act_f()}
        !== {1'b0, 1'b0, 32'd0, ref_f(last_w)}) begin
      n_err++;
      $display("FAIL abort_capt: got b=%b v=%b pc=%h f=%h",
               bus.busy, bus.ir_valid, bus.pc, act_f());
    end
    do_fetch(cyc);
    @(negedge clk);
    bus.clear_pc = 1'b1;
    bus.load_pc = 1'b1;
    bus.pc_in = 32'h123;
    @(negedge clk);
    bus.clear_pc = 1'b0;
    bus.load_pc = 1'b0;
    n_cmp++;
    if ({bus.pc, bus.ir_valid, bus.busy}
        !== {32'd0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL clr_and_ld: got pc=%h v=%b b=%b",
               bus.pc, bus.ir_valid, bus.busy);
    end
    last_w = mem[0];
  endtask

  task automatic test_ignore_capture;
    @(negedge clk) bus.fetch_req = 1'b1;
    @(negedge clk) bus.fetch_req = 1'b0;
    @(negedge clk) bus.fetch_req = 1'b1;
    @(negedge clk) bus.fetch_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.ir_valid, bus.busy, bus.pc, act_f()}
        !== {1'b1, 1'b0, 32'd4, ref_f(mem[0])}) begin
      n_err++;
      $display("FAIL ignore_capt: got v=%b b=%b pc=%h f=%h",
               bus.ir_valid, bus.busy, bus.pc, act_f());
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] w;
    set_pc(32'h200);
    for (int i = 0; i < 6; i++) begin
      w = $urandom;
      w[27:26] = 2'b00;
      mem[128 + i] = w;
    end
    @(negedge clk) bus.fetch_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      repeat (2) begin
        @(negedge clk);
        n_cmp++;
        if ({bus.busy, bus.ir_valid} !== 2'b10) begin
          n_err++;
          $display("FAIL b2b_busy[%0d]: got b=%b v=%b",
                   i, bus.busy, bus.ir_valid);
        end
      end
      @(negedge clk);
      n_cmp++;
      if ({bus.ir_valid, bus.pc, act_f()}
          !== {1'b1, 32'h200 + 32'(4 * (i + 1)),
               ref_f(mem[128 + i])}) begin
        n_err++;
        $display("FAIL b2b_word[%0d]: got v=%b pc=%h f=%h",
                 i, bus.ir_valid, bus.pc, act_f());
      end
    end
    bus.fetch_req = 1'b0;
  endtask

  task automatic test_random;
    int cyc;
    int a;
    logic [31:0] w;
    logic [31:0] pcv;
    for (int i = 0; i < 150; i++) begin
      a = $urandom_range(0, DEPTH - 1);
      pcv = $urandom;
      if (i == 0) begin
        pcv = 32'hFFFFFFFC;
        a = DEPTH - 1;
      end
      pcv[AW+1:2] = a[AW-1:0];
      w = $urandom;
      if ($urandom_range(0, 3) != 0) w[27:26] = 2'b00;
      mem[a] = w;
      set_pc(pcv);
      n_cmp++;
      if (bus.ram_addr !== a[AW-1:0]) begin
        n_err++;
        $display("FAIL rnd_addr[%0d]: got %h want %h",
                 i, bus.ram_addr, a[AW-1:0]);
      end
      do_fetch(cyc);
      n_cmp++;
      if ({cyc[3:0], bus.pc, act_f()}
          !== {4'd3, pcv + 32'd4, ref_f(w)}) begin
        n_err++;
        $display("FAIL rnd_fetch[%0d]: got c=%0d pc=%h f=%h want %h",
                 i, cyc, bus.pc, act_f(), ref_f(w));
      end
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk) bus.fetch_req = 1'b1;
    @(negedge clk) bus.fetch_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.pc, bus.ir_valid, bus.busy, act_f()}
        !== {32'd0, 1'b0, 1'b0, 7'b0000010, 60'd0}) begin
      n_err++;
      $display("FAIL reset_mid: got pc=%h v=%b b=%b f=%h",
               bus.pc, bus.ir_valid, bus.busy, act_f());
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    bus.fetch_req = 1'b0;
    bus.load_pc = 1'b0;
    bus.clear_pc = 1'b0;
    bus.pc_in = 32'd0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'd0;
    test_reset();
    test_directed();
    test_abort_load();
    test_clear_pc();
    test_ignore_capture();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
